// File: rtl/tcb_arb_rr.sv
// Round-robin arbiter sharing one TCB subordinate between PN TCB managers.
// Grants one request per cycle, holds the grant while the device stalls, and
// tracks which port owns each in-flight response so errors return to the issuer.
module tcb_arb_rr #(
  parameter int AW  = 32,
  parameter int DW  = 32,
  parameter int BW  = DW/8,
  parameter int PN  = 3,
  parameter int DLY = 1
)(
  input  logic             clk,
  input  logic             rst_n,
  // manager-facing ports (one per requester)
  input  logic [PN-1:0]    sub_vld,
  input  logic [PN-1:0]    sub_wen,
  input  logic [PN*BW-1:0] sub_ben,
  input  logic [PN*AW-1:0] sub_adr,
  input  logic [PN*DW-1:0] sub_wdt,
  output logic [PN-1:0]    sub_rdy,
  output logic [DW-1:0]    sub_rdt,
  output logic [PN-1:0]    sub_err,
  // shared device port
  output logic             man_vld,
  output logic             man_wen,
  output logic [BW-1:0]    man_ben,
  output logic [AW-1:0]    man_adr,
  output logic [DW-1:0]    man_wdt,
  input  logic             man_rdy,
  input  logic [DW-1:0]    man_rdt,
  input  logic             man_err
);

  localparam int IW = (PN > 1) ? $clog2(PN) : 1;

  if (PN < 2) begin : g_chk_pn
    $error("tcb_arb_rr: PN must be at least 2");
  end
  if (DLY < 0 || DLY > 4) begin : g_chk_dly
    $error("tcb_arb_rr: DLY must be within 0..4");
  end

  logic [IW-1:0] ptr;       // last served port
  logic [IW-1:0] gnt_q;     // grant held across a stall
  logic          lck;       // grant is frozen while the device stalls
  logic [IW-1:0] gnt_srch;  // round-robin search result
  logic          srch_hit;
  logic [IW-1:0] gnt;       // effective grant this cycle
  logic          man_trn;
  int            cand_i;
  logic [IW-1:0] cand;

  // Round-robin search: first requester after the last served port, wrapping.
  always_comb begin
    gnt_srch = ptr;
    srch_hit = 1'b0;
    cand_i   = 0;
    cand     = '0;
    for (int k = 1; k <= PN; k++) begin
      cand_i = int'(ptr) + k;
      if (cand_i >= PN) cand_i = cand_i - PN;
      cand = IW'(cand_i);
      if (!srch_hit && sub_vld[cand]) begin
        gnt_srch = cand;
        srch_hit = 1'b1;
      end
    end
  end

  assign gnt     = lck ? gnt_q : gnt_srch;
  assign man_vld = lck ? sub_vld[gnt_q] : |sub_vld;
  assign man_trn = man_vld & man_rdy;

  assign man_wen = sub_wen[gnt];
  assign man_ben = sub_ben[int'(gnt)*BW +: BW];
  assign man_adr = sub_adr[int'(gnt)*AW +: AW];
  assign man_wdt = sub_wdt[int'(gnt)*DW +: DW];

  // Ready goes back only to the granted, requesting port.
  always_comb begin
    sub_rdy = '0;
    for (int i = 0; i < PN; i++) begin
      sub_rdy[i] = man_rdy & sub_vld[i] & (gnt == IW'(i));
    end
  end

  // Priority pointer and stall lock.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr   <= IW'(PN-1);
      lck   <= 1'b0;
      gnt_q <= '0;
    end else begin
      if (man_vld && !man_rdy) begin
        lck   <= 1'b1;
        gnt_q <= gnt;
      end else if (man_trn) begin
        lck   <= 1'b0;
      end
      if (man_trn) ptr <= gnt;
    end
  end

  logic          own_vld;
  logic [IW-1:0] own_idx;

  if (DLY == 0) begin : g_own_comb
    assign own_vld = man_trn;
    assign own_idx = gnt;
  end else begin : g_own_pipe
    logic [DLY-1:0] vld_p;
    logic [IW-1:0]  idx_p [DLY];

    // Ownership valid bits: cleared on reset so in-flight responses are dropped.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        vld_p <= '0;
      end else begin
        vld_p[0] <= man_trn;
        for (int s = 1; s < DLY; s++) vld_p[s] <= vld_p[s-1];
      end
    end

    // Ownership index travels alongside its valid bit.
    always_ff @(posedge clk) begin
      idx_p[0] <= gnt;
      for (int s = 1; s < DLY; s++) idx_p[s] <= idx_p[s-1];
    end

    assign own_vld = vld_p[DLY-1];
    assign own_idx = idx_p[DLY-1];
  end

  assign sub_rdt = man_rdt;

  // Route the device error to the port that owns the current response.
  always_comb begin
    sub_err = '0;
    for (int i = 0; i < PN; i++) begin
      sub_err[i] = man_err & own_vld & (own_idx == IW'(i));
    end
  end

endmodule
